button_event_classifier: RTL and testbench



---
 rtl/button_event_classifier.sv | 185 ++++++++++++++++++
 tb/tb_button_event_classifier.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_classifier.sv
// ---------------------------------------------------------------------------
// button_event_classifier
//
// Purpose:
//   Turns the clean, clock-synchronous level coming out of the debouncer into
//   one-cycle event pulses for the user-interface logic: press, release,
//   single click, double click, long press and (optionally) auto-repeat while
//   the button is held past the long-press threshold.
//
// Optional feature:
//   Define BTN_AUTOREPEAT_EN to build the auto-repeat generator. Without it,
//   repeat_tick is tied low and the LONG state keeps the timer at zero.
//
// Parameters:
//   LONG_TICKS        cycles a press must be held before long_press (min 2)
//   DOUBLE_GAP_TICKS  max cycles after a short release in which a second
//                     press counts as a double click (min 2)
//   REPEAT_TICKS      auto-repeat period while long-held (min 2)
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   btn_in         in   debounced button level, synchronous to clk
//   press          out  one-cycle pulse per rising edge of btn_in
//   release_pulse  out  one-cycle pulse per falling edge of btn_in
//                       ("release" alone is a reserved word in the language)
//   single_click   out  short press with no second press inside the gap
//   double_click   out  second press started inside the gap
//   long_press     out  press held for LONG_TICKS cycles
//   repeat_tick    out  periodic pulse while long-held (auto-repeat builds)
// ---------------------------------------------------------------------------
module button_event_classifier #(
    parameter int LONG_TICKS       = 100_000_000,
    parameter int DOUBLE_GAP_TICKS = 25_000_000,
    parameter int REPEAT_TICKS     = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic press,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_tick
);

    // One timer serves every state, so it is sized for the largest interval.
    localparam int MAX_LG    = (LONG_TICKS > DOUBLE_GAP_TICKS) ? LONG_TICKS : DOUBLE_GAP_TICKS;
    localparam int MAX_TICKS = (MAX_LG > REPEAT_TICKS) ? MAX_LG : REPEAT_TICKS;
    localparam int TW        = $clog2(MAX_TICKS) + 1;

    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(DOUBLE_GAP_TICKS - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_TICKS - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        HELD1,
        LONG,
        GAP,
        HELD2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          btn_q;
    logic          rise;
    logic          fall;

    // btn_q starts at 0, so a button held through reset still reports a press.
    assign rise = btn_in & ~btn_q;
    assign fall = ~btn_in & btn_q;

`ifdef BTN_AUTOREPEAT_EN
    logic repeat_q;
    assign repeat_tick = repeat_q;
`else
    assign repeat_tick = 1'b0;
`endif

    // Gesture classifier. Every pulse output is a register that defaults low
    // each cycle and is set only on the edge that recognises its event.
    // The timer is cleared on each state entry; in IDLE and HELD2 it has no
    // job, so it is parked at zero there rather than left counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            btn_q         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            single_click  <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            repeat_q      <= 1'b0;
`endif
        end else begin
            btn_q         <= btn_in;
            press         <= rise;
            release_pulse <= fall;
            single_click  <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            repeat_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (rise) begin
                        state <= HELD1;
                    end
                end

                // A release always beats a coinciding long-press terminal count.
                HELD1: begin
                    if (fall) begin
                        state <= GAP;
                        timer <= '0;
                    end else if (timer == LONG_LAST) begin
                        long_press <= 1'b1;
                        state      <= LONG;
                        timer      <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                // A release ends the gesture without any click; a release on
                // the repeat terminal edge suppresses that tick.
                LONG: begin
                    if (fall) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
`ifdef BTN_AUTOREPEAT_EN
                        if (timer == REPEAT_LAST) begin
                            repeat_q <= 1'b1;
                            timer    <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
`else
                        timer <= '0;
`endif
                    end
                end

                // A second press on the gap terminal edge still counts as a
                // double click.
                GAP: begin
                    if (rise) begin
                        double_click <= 1'b1;
                        state        <= HELD2;
                        timer        <= '0;
                    end else if (timer == GAP_LAST) begin
                        single_click <= 1'b1;
                        state        <= IDLE;
                        timer        <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                // The second press of a double click is never timed for long.
                HELD2: begin
                    timer <= '0;
                    if (fall) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_classifier.sv
// ---------------------------------------------------------------------------
// tb_button_event_classifier
//
// Drives button_event_classifier with directed gestures and randomized
// press/release runs, comparing all six pulse outputs every cycle against a
// timestamp-based reference model. Honours BTN_AUTOREPEAT_EN like the design.
// Output vectors are printed as {press,release,single,double,long,repeat}.
// ---------------------------------------------------------------------------
module tb_button_event_classifier;

    localparam int LT = 20;
    localparam int DG = 10;
    localparam int RT = 5;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic btn_in = 1'b0;

    logic press, release_pulse, single_click, double_click, long_press, repeat_tick;
    logic [5:0] obs;
    logic [5:0] exp_v;

    int errors = 0;
    int checks = 0;

    // Reference model state: edge counter and timestamps of pending gestures.
    int   n       = 0;
    int   press_t = -1;
    int   gap_t   = -1;
    int   long_t  = -1;
    logic prev_b  = 1'b0;

    always #5 clk = ~clk;

    button_event_classifier #(
        .LONG_TICKS      (LT),
        .DOUBLE_GAP_TICKS(DG),
        .REPEAT_TICKS    (RT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .press        (press),
        .release_pulse(release_pulse),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_tick  (repeat_tick)
    );

    assign obs = {press, release_pulse, single_click, double_click, long_press, repeat_tick};

    // Expected outputs after clock edge n, from gesture timestamps:
    // press_t = start of a first press still being timed,
    // gap_t   = release of a short press awaiting a possible second press,
    // long_t  = edge at which long_press fired while still held.
    task automatic model_edge(input logic b, input logic rst);
        logic rise, fall;
        n++;
        exp_v = '0;
        if (rst) begin
            prev_b  = 1'b0;
            press_t = -1;
            gap_t   = -1;
            long_t  = -1;
            return;
        end
        rise   = b & ~prev_b;
        fall   = ~b & prev_b;
        prev_b = b;
        exp_v[5] = rise;
        exp_v[4] = fall;
        if (gap_t >= 0) begin
            if (rise) begin
                exp_v[2] = 1'b1;
                gap_t    = -1;
            end else if (n - gap_t == DG) begin
                exp_v[3] = 1'b1;
                gap_t    = -1;
            end
        end else if (rise) begin
            press_t = n;
        end
        if (press_t >= 0 && press_t != n) begin
            if (fall) begin
                gap_t   = n;
                press_t = -1;
            end else if (n - press_t == LT) begin
                exp_v[1] = 1'b1;
                long_t   = n;
                press_t  = -1;
            end
        end else if (long_t >= 0 && long_t != n) begin
            if (fall) begin
                long_t = -1;
            end else if ((n - long_t) % RT == 0) begin
`ifdef BTN_AUTOREPEAT_EN
                exp_v[0] = 1'b1;
`endif
            end
        end
    endtask

    // One clock: drive inputs, let the DUT sample them, advance the model,
    // then settle just past the edge before anything is compared.
    task automatic tick(input logic b, input logic rst);
        btn_in = b;
        reset  = rst;
        @(posedge clk);
        model_edge(b, rst);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("[TB] FAIL reset cyc=%0d got=%b want=%b", n, obs, 6'b0);
            end
        end
    endtask

    task automatic test_single_click();
        int   len[3] = '{3, 5, 15};
        logic lvl[3] = '{1'b0, 1'b1, 1'b0};
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < len[s]; i++) begin
                tick(lvl[s], 1'b0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL single_click cyc=%0d got=%b want=%b", n, obs, exp_v);
                end
            end
        end
    endtask

    // Gaps of 4, 9, 10 (terminal edge) and 11 low cycles between presses.
    task automatic test_double_click();
        int   len[16] = '{5, 4, 5, 15, 5, 9, 5, 15, 5, 10, 5, 15, 5, 11, 5, 15};
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < len[s]; i++) begin
                tick((s % 2) == 0, 1'b0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL double_click cyc=%0d got=%b want=%b", n, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_long_press();
        int press_at = -1;
        int long_at  = -1;
        for (int i = 0; i < 55; i++) begin
            tick(i < 40, 1'b0);
            if (press) press_at = n;
            if (long_press) long_at = n;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("[TB] FAIL long_press cyc=%0d got=%b want=%b", n, obs, exp_v);
            end
        end
        checks++;
        if (long_at - press_at !== LT) begin
            errors++;
            $display("[TB] FAIL long_latency got=%0d want=%0d", long_at - press_at, LT);
        end
    endtask

    // Holds of 19, 20 (release on the terminal edge) and 21 cycles.
    task automatic test_long_boundary();
        int len[6] = '{19, 15, 20, 15, 21, 15};
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < len[s]; i++) begin
                tick((s % 2) == 0, 1'b0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL long_boundary cyc=%0d got=%b want=%b", n, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid_gap();
        int   len[6] = '{5, 3, 2, 15, 5, 15};
        logic lvl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic rst[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < len[s]; i++) begin
                tick(lvl[s], rst[s]);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_gap cyc=%0d got=%b want=%b", n, obs, exp_v);
                end
            end
        end
    endtask

    // Button held through reset must still produce a press afterwards.
    task automatic test_reset_held();
        int   len[3] = '{2, 4, 15};
        logic lvl[3] = '{1'b1, 1'b1, 1'b0};
        logic rst[3] = '{1'b1, 1'b0, 1'b0};
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < len[s]; i++) begin
                tick(lvl[s], rst[s]);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL reset_held cyc=%0d got=%b want=%b", n, obs, exp_v);
                end
            end
        end
    endtask

    // Alternating random-length runs with occasional short resets.
    task automatic test_random();
        logic lvl = 1'b0;
        for (int s = 0; s < 120; s++) begin
            int   len;
            logic rst;
            rst = ($urandom_range(0, 19) == 0);
            len = rst ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 30));
            if (!rst) lvl = ~lvl;
            for (int i = 0; i < len; i++) begin
                tick(lvl, rst);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL random cyc=%0d got=%b want=%b", n, obs, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_click();
        test_double_click();
        test_long_press();
        test_long_boundary();
        test_reset_mid_gap();
        test_reset_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
